hazard_unit: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. It is the stall-side counterpart of the EX-stage forwarding logic: it handles every dependency that forwarding cannot resolve. These are load-use hazards, ID-stage branch operand hazards (including the two-cycle branch-after-load case), taken-branch/jump flushes, and multi-cycle data-memory waits. It sits beside the ID stage and drives the PC, IF/ID and ID/EX register enables, plus a global pipeline freeze.

---
 rtl/hazard_unit.sv | 132 +++++++++++++
 tb/tb_hazard_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: load-use, ID-branch operand hazards, flushes and data-memory waits.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_uses_Rt,
  input  logic             ID_is_branch,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic             EX_MEM_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, STALL2, MEM_WAIT} state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d, eff_state;
  logic       ret_q, ret_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_err_q, mem_err_d;
  logic       ex_match, mem_stall;

  assign ex_match = (ID_EX_Rd != 5'd0) &&
                    ((ID_EX_Rd == IF_ID_Rs) || (ID_uses_Rt && (ID_EX_Rd == IF_ID_Rt)));

  // The cycle mem_ready rises releases the freeze; the pipeline then behaves as the saved state.
  assign mem_stall = !mem_ready && ((state_q == MEM_WAIT) || EX_MEM_req);
  assign eff_state = (state_q == MEM_WAIT) ? (ret_q ? STALL2 : RUN) : state_q;

  // NOTE: every output and next-state gets a default first so no path leaves a latch.
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    pipe_freeze  = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    if (rst) begin
      state_d = RUN;
      ret_d   = 1'b0;
    end else if (mem_stall) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      IF_ID_Write = 1'b0;
      state_d     = MEM_WAIT;
      ret_d       = (eff_state == STALL2);
    end else if (eff_state == STALL2) begin
      pc_write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      state_d      = RUN;
      ret_d        = 1'b0;
    end else begin
      state_d = RUN;
      ret_d   = 1'b0;
      if (ID_EX_MemRead && ex_match) begin
        pc_write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        if (ID_is_branch) state_d = STALL2;
      end else if (ID_is_branch && ID_EX_RegWrite && ex_match) begin
        pc_write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else if (branch_taken || jump) begin
        IF_ID_Flush = 1'b1;
      end
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (mem_stall) begin
      if (state_q != MEM_WAIT)  wait_d = 8'd0;
      else if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
    end
    mem_err_d = mem_err_q || (wait_d == TIMEOUT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      ret_q     <= 1'b0;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (instantiated with MEM_TIMEOUT=4).
// Control outputs are compared as {pc_write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, pipe_freeze}.
module tb_hazard_unit;

  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00100;
  localparam logic [4:0] C_FLUSH  = 5'b11010;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rd;
  logic        ID_uses_Rt, ID_is_branch, branch_taken, jump;
  logic        ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_req, mem_ready;
  logic        pc_write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, pipe_freeze, mem_err;
  logic [15:0] stall_cnt;
  logic [4:0]  ctl;
  logic [15:0] exp_stalls;
  int          checks = 0;
  int          errors = 0;

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_uses_Rt(ID_uses_Rt),
    .ID_is_branch(ID_is_branch), .branch_taken(branch_taken), .jump(jump),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_req(EX_MEM_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .pipe_freeze(pipe_freeze), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  assign ctl = {pc_write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, pipe_freeze};

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_cnt();
`ifdef HAZARD_PERF_CNT_EN
    return exp_stalls;
`else
    return 16'd0;
`endif
  endfunction

  task automatic clear_inputs();
    IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_uses_Rt = 1'b0; ID_is_branch = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; ID_EX_Rd = 5'd0; ID_EX_RegWrite = 1'b0;
    ID_EX_MemRead = 1'b0; EX_MEM_req = 1'b0; mem_ready = 1'b1;
  endtask

  // Bubble entering ID/EX after a stall cycle.
  task automatic bubble_ex();
    ID_EX_Rd = 5'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
  endtask

  task automatic tick(input logic stalled);
    @(posedge clk);
    #1;
    if (stalled) exp_stalls++;
  endtask

  task automatic test_reset();
    rst = 1'b1; exp_stalls = '0;
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd3; IF_ID_Rs = 5'd3;
    #12;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL reset_forced_ctl: got %b want %b", ctl, C_RUN); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    clear_inputs();
    #1 rst = 1'b0;
    tick(1'b0);
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL reset_idle_ctl: got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_load_use();
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd2; IF_ID_Rs = 5'd2;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL load_use_stall: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    bubble_ex();
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL load_use_release: got %b want %b", ctl, C_RUN); end
    checks++; if (stall_cnt !== exp_cnt()) begin errors++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt()); end
    // Rt match only counts when the instruction reads Rt.
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd9; IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd9; ID_uses_Rt = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL load_use_rt_unused: got %b want %b", ctl, C_RUN); end
    ID_uses_Rt = 1'b1;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL load_use_rt_used: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    clear_inputs();
  endtask

  task automatic test_reg0();
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_uses_Rt = 1'b1;
    ID_is_branch = 1'b1; ID_EX_RegWrite = 1'b1;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL reg0_no_stall: got %b want %b", ctl, C_RUN); end
    tick(1'b0);
    clear_inputs();
  endtask

  task automatic test_branch_after_load();
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd5; ID_is_branch = 1'b1; IF_ID_Rs = 5'd1;
    IF_ID_Rt = 5'd5; ID_uses_Rt = 1'b1; branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL bal_cycle1: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    bubble_ex();
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL bal_cycle2: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL bal_flush: got %b want %b", ctl, C_FLUSH); end
    checks++; if (stall_cnt !== exp_cnt()) begin errors++; $display("FAIL bal_cnt: got %0d want %0d", stall_cnt, exp_cnt()); end
    tick(1'b0);
    clear_inputs();
  endtask

  task automatic test_branch_alu();
    ID_EX_RegWrite = 1'b1; ID_EX_Rd = 5'd7; ID_is_branch = 1'b1; IF_ID_Rs = 5'd7; branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL balu_stall: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    bubble_ex();
    #1;
    checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL balu_flush: got %b want %b", ctl, C_FLUSH); end
    tick(1'b0);
    clear_inputs();
    // Non-branch consumer of an ALU result is covered by forwarding.
    ID_EX_RegWrite = 1'b1; ID_EX_Rd = 5'd7; IF_ID_Rs = 5'd7;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL alu_no_branch: got %b want %b", ctl, C_RUN); end
    tick(1'b0);
    clear_inputs();
  endtask

  task automatic test_jump_flush();
    jump = 1'b1;
    #1;
    checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL jump_flush: got %b want %b", ctl, C_FLUSH); end
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd4; IF_ID_Rs = 5'd4;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL jump_under_stall: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    EX_MEM_req = 1'b1; mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL mem_ready_same_cycle: got %b want %b", ctl, C_RUN); end
    tick(1'b0);
    EX_MEM_req = 1'b0; mem_ready = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL mem_no_wait_entered: got %b want %b", ctl, C_RUN); end
    EX_MEM_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL mem_freeze_%0d: got %b want %b", i, ctl, C_FREEZE); end
      tick(1'b1);
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL mem_release: got %b want %b", ctl, C_RUN); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mem_err_short: got %b want 0", mem_err); end
    tick(1'b0);
    clear_inputs();
    #1;
    checks++; if (stall_cnt !== exp_cnt()) begin errors++; $display("FAIL mem_cnt: got %0d want %0d", stall_cnt, exp_cnt()); end
  endtask

  task automatic test_stall2_mem_wait();
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd6; ID_is_branch = 1'b1; IF_ID_Rs = 5'd6; branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL s2m_cycle1: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    bubble_ex(); EX_MEM_req = 1'b1; mem_ready = 1'b0;
    #1;
    checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL s2m_freeze: got %b want %b", ctl, C_FREEZE); end
    tick(1'b1);
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL s2m_resume: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    EX_MEM_req = 1'b0;
    #1;
    checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL s2m_flush: got %b want %b", ctl, C_FLUSH); end
    tick(1'b0);
    clear_inputs();
  endtask

  task automatic test_timeout();
    EX_MEM_req = 1'b1; mem_ready = 1'b0;
    #1;
    checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL to_enter: got %b want %b", ctl, C_FREEZE); end
    tick(1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1);
      checks++; if (mem_err !== (i == 4)) begin errors++; $display("FAIL to_mem_err_%0d: got %b want %b", i, mem_err, (i == 4)); end
    end
    checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL to_freeze_holds: got %b want %b", ctl, C_FREEZE); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_rst_mem_err: got %b want 0", mem_err); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL to_rst_ctl: got %b want %b", ctl, C_RUN); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL to_rst_cnt: got %0d want 0", stall_cnt); end
    exp_stalls = '0;
    clear_inputs();
    #1 rst = 1'b0;
    tick(1'b0);
  endtask

  task automatic test_reset_stall2();
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd8; ID_is_branch = 1'b1; IF_ID_Rs = 5'd8;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL rs2_cycle1: got %b want %b", ctl, C_STALL); end
    tick(1'b1);
    bubble_ex();
    #1 rst = 1'b1;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rs2_forced: got %b want %b", ctl, C_RUN); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rs2_cnt: got %0d want 0", stall_cnt); end
    exp_stalls = '0;
    #1 rst = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rs2_no_bubble: got %b want %b", ctl, C_RUN); end
    tick(1'b0);
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rs2_run_next: got %b want %b", ctl, C_RUN); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rs2_cnt_after: got %0d want 0", stall_cnt); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg0();
    test_branch_after_load();
    test_branch_alu();
    test_jump_flush();
    test_mem_wait();
    test_stall2_mem_wait();
    test_timeout();
    test_reset_stall2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
